// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store unit. Takes the ALU result as the effective byte
//   address and RD2 as store data. It runs one sized little-endian access on a
//   req/ack data bus and stalls the core until that access completes. Loads are
//   returned sign- or zero-extended. Misaligned and illegal accesses are rejected
//   without any bus traffic. A bounded wait counter turns a hung bus into an error.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     MemReq, MemWrite      access request (sampled in IDLE) and store select
//     Funct3                000 B, 001 H, 010 W, 100 BU, 101 HU (others illegal)
//     ALUResult, WriteData  effective address, store data
//     Stall, Done           pipeline hold, one-cycle completion pulse
//     ReadData              extended load result, held until the next load
//     Fault, BusError       one-cycle pulses: rejected access, bus timeout
//     bus_*                 data-memory request/response bus
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic        Fault,
  output logic        BusError,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam int unsigned     CW   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   LAST = CW'(MAX_WAIT - 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   readdata_q;

  logic          illegal;
  logic          misaligned;
  logic [3:0]    strb_n;
  logic [31:0]   wdata_n;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_ext;

  // Request decode: legality, alignment and store lane placement.
  always_comb begin
    illegal    = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11);
    misaligned = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                 ((Funct3 == 3'b010) && (ALUResult[1:0] != 2'b00));
    strb_n  = 4'b1111;
    wdata_n = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        strb_n  = 4'b0001 << ALUResult[1:0];
        wdata_n = {4{WriteData[7:0]}};
      end
      2'b01: begin
        strb_n  = 4'b0011 << ALUResult[1:0];
        wdata_n = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
    if (!MemWrite) strb_n = '0;
  end

  // Load lane extraction from the word on the bus.
  always_comb begin
    lane_b = bus_rdata[7:0];
    case (off_q)
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      2'd3:    lane_b = bus_rdata[31:24];
      default: lane_b = bus_rdata[7:0];
    endcase
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      readdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemReq) begin
            timeout_q <= 1'b0;
            if (illegal || misaligned) begin
              state <= ERR;
            end else begin
              state    <= REQ;
              wait_cnt <= '0;
              f3_q     <= Funct3;
              off_q    <= ALUResult[1:0];
              we_q     <= MemWrite;
              addr_q   <= {ALUResult[31:2], 2'b00};
              wdata_q  <= wdata_n;
              wstrb_q  <= strb_n;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            // The load result is registered on the ack edge so that it is
            // already visible in the RESP cycle alongside Done.
            if (!we_q) readdata_q <= load_ext;
            state <= RESP;
          end else if (wait_cnt == LAST) begin
            timeout_q <= 1'b1;
            state     <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Stall     = ((state == IDLE) && MemReq) || (state == REQ);
  assign Done      = (state == RESP) || (state == ERR);
  assign Fault     = (state == ERR) && !timeout_q;
  assign BusError  = (state == ERR) && timeout_q;
  assign ReadData  = readdata_q;
  assign bus_req   = (state == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  typedef struct packed {
    logic [7:0]  done_cyc;
    logic [7:0]  reqcnt;
    logic [7:0]  stallcnt;
    logic        stall0;
    logic        fault;
    logic        berr;
    logic        we;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } res_t;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          ack;
    logic [31:0] rdata;
  } stim_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        MemReq = 0, MemWrite = 0;
  logic [2:0]  Funct3 = '0;
  logic [31:0] ALUResult = '0, WriteData = '0;
  logic        Stall, Done, Fault, BusError;
  logic [31:0] ReadData;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 0;
  logic [31:0] bus_rdata = '0;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd = '0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemReq(MemReq), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .Stall(Stall), .Done(Done), .ReadData(ReadData), .Fault(Fault),
    .BusError(BusError), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  function automatic res_t mk(int dc, int rq, logic fault, logic berr, logic we,
                              logic [31:0] rd, logic [31:0] addr,
                              logic [31:0] wdata, logic [3:0] wstrb);
    res_t r;
    r.done_cyc = 8'(dc);
    r.reqcnt   = 8'(rq);
    r.stallcnt = 8'(rq);
    r.stall0   = 1'b1;
    r.fault    = fault;
    r.berr     = berr;
    r.we       = we;
    r.rd       = rd;
    r.addr     = addr;
    r.wdata    = wdata;
    r.wstrb    = wstrb;
    return r;
  endfunction

  // Issues one request in cycle 0 and watches cycles 1..40 until Done.
  // ack = 0 means the memory never acknowledges.
  task automatic run_access(input stim_t s, output res_t r);
    bit first = 1;
    r = '0;
    @(posedge clk); #1;
    MemReq = 1; MemWrite = s.we; Funct3 = s.f3;
    ALUResult = s.addr; WriteData = s.wd;
    @(negedge clk);
    r.stall0 = Stall;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      MemReq    = 0;
      bus_ack   = (cyc == s.ack);
      bus_rdata = (cyc == s.ack) ? s.rdata : 32'h0;
      @(negedge clk);
      if (bus_req) begin
        r.reqcnt = r.reqcnt + 8'd1;
        if (first) begin
          r.addr = bus_addr; r.wdata = bus_wdata;
          r.wstrb = bus_wstrb; r.we = bus_we;
          first = 0;
        end
      end
      if (Stall) r.stallcnt = r.stallcnt + 8'd1;
      if (Done) begin
        r.done_cyc = 8'(cyc);
        r.fault = Fault; r.berr = BusError; r.rd = ReadData;
        break;
      end
    end
    bus_ack = 0;
    bus_rdata = '0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    total++;
    if ({Stall, Done, Fault, BusError, bus_req, bus_we} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {Stall, Done, Fault, BusError, bus_req, bus_we});
    end
    total++;
    if ({bus_addr, bus_wdata, ReadData, bus_wstrb} !== '0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h rd=%h strb=%b want zeros",
               bus_addr, bus_wdata, ReadData, bus_wstrb);
    end
  endtask

  task automatic check_list(input stim_t st[$]);
    res_t obs, e;
    foreach (st[i]) begin
      run_access(st[i], obs);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s: got dc=%0d req=%0d stl=%0d s0=%b f=%b be=%b we=%b rd=%h ad=%h wd=%h st=%b, want dc=%0d req=%0d stl=%0d s0=%b f=%b be=%b we=%b rd=%h ad=%h wd=%h st=%b",
                 st[i].name, obs.done_cyc, obs.reqcnt, obs.stallcnt, obs.stall0, obs.fault,
                 obs.berr, obs.we, obs.rd, obs.addr, obs.wdata, obs.wstrb,
                 e.done_cyc, e.reqcnt, e.stallcnt, e.stall0, e.fault, e.berr, e.we,
                 e.rd, e.addr, e.wdata, e.wstrb);
      end
    end
  endtask

  task automatic test_load_word;
    stim_t st[$];
    st.push_back('{"lw_0x100", 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF});
    exp_q.push_back(mk(2, 1, 0, 0, 0, 32'hDEADBEEF, 32'h100, 32'h0, 4'b0000));
    st.push_back('{"lw_wait3", 1'b0, 3'b010, 32'h7FC, 32'h0, 3, 32'h0BADF00D});
    exp_q.push_back(mk(4, 3, 0, 0, 0, 32'h0BADF00D, 32'h7FC, 32'h0, 4'b0000));
    last_rd = 32'h0BADF00D;
    check_list(st);
  endtask

  task automatic test_store;
    stim_t st[$];
    st.push_back('{"sb_0x203", 1'b1, 3'b000, 32'h203, 32'h12345678, 1, 32'hFFFFFFFF});
    exp_q.push_back(mk(2, 1, 0, 0, 1, last_rd, 32'h200, 32'h78787878, 4'b1000));
    st.push_back('{"sh_0x2", 1'b1, 3'b001, 32'h2, 32'h1234ABCD, 2, 32'h0});
    exp_q.push_back(mk(3, 2, 0, 0, 1, last_rd, 32'h0, 32'hABCDABCD, 4'b1100));
    st.push_back('{"sw_0x10", 1'b1, 3'b010, 32'h10, 32'hCAFE0001, 1, 32'h0});
    exp_q.push_back(mk(2, 1, 0, 0, 1, last_rd, 32'h10, 32'hCAFE0001, 4'b1111));
    check_list(st);
  endtask

  task automatic test_load_ext;
    stim_t st[$];
    st.push_back('{"lb_0x2", 1'b0, 3'b000, 32'h2, 32'h0, 1, 32'h00800000});
    exp_q.push_back(mk(2, 1, 0, 0, 0, 32'hFFFFFF80, 32'h0, last_rd == 0 ? 32'h0 : 32'h0, 4'b0000));
    st.push_back('{"lbu_0x2", 1'b0, 3'b100, 32'h2, 32'h0, 1, 32'h00800000});
    exp_q.push_back(mk(2, 1, 0, 0, 0, 32'h00000080, 32'h0, 32'h0, 4'b0000));
    st.push_back('{"lh_0x2", 1'b0, 3'b001, 32'h2, 32'h0, 1, 32'h80010000});
    exp_q.push_back(mk(2, 1, 0, 0, 0, 32'hFFFF8001, 32'h0, 32'h0, 4'b0000));
    st.push_back('{"lhu_0x2", 1'b0, 3'b101, 32'h2, 32'h0, 1, 32'h80010000});
    exp_q.push_back(mk(2, 1, 0, 0, 0, 32'h00008001, 32'h0, 32'h0, 4'b0000));
    st.push_back('{"lb_0x7", 1'b0, 3'b000, 32'h7, 32'h0, 2, 32'h7F112233});
    exp_q.push_back(mk(3, 2, 0, 0, 0, 32'h0000007F, 32'h4, 32'h0, 4'b0000));
    last_rd = 32'h0000007F;
    check_list(st);
  endtask

  task automatic test_faults;
    stim_t st[$];
    res_t e;
    st.push_back('{"lh_misaligned", 1'b0, 3'b001, 32'h1, 32'h0, 1, 32'h0});
    st.push_back('{"sw_misaligned", 1'b1, 3'b010, 32'h6, 32'h55, 1, 32'h0});
    st.push_back('{"f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0});
    st.push_back('{"f3_111", 1'b0, 3'b111, 32'h8, 32'h0, 1, 32'h0});
    for (int i = 0; i < 4; i++) begin
      e = mk(1, 0, 1, 0, 0, last_rd, 32'h0, 32'h0, 4'b0000);
      // bus outputs still show the last accepted access; they are not sampled
      // because bus_req never rises, so the observed copies stay zero
      exp_q.push_back(e);
    end
    check_list(st);
  endtask

  task automatic test_timeout;
    stim_t st[$];
    st.push_back('{"timeout", 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h0});
    exp_q.push_back(mk(5, 4, 0, 1, 0, last_rd, 32'h40, 32'h0, 4'b0000));
    st.push_back('{"ack_last_cycle", 1'b0, 3'b010, 32'h44, 32'h0, 4, 32'h13579BDF});
    exp_q.push_back(mk(5, 4, 0, 0, 0, 32'h13579BDF, 32'h44, 32'h0, 4'b0000));
    last_rd = 32'h13579BDF;
    check_list(st);
  endtask

  task automatic test_back_to_back;
    stim_t st[$];
    st.push_back('{"b2b_lbu", 1'b0, 3'b100, 32'h3, 32'h0, 1, 32'hA5000000});
    exp_q.push_back(mk(2, 1, 0, 0, 0, 32'h000000A5, 32'h0, 32'h0, 4'b0000));
    st.push_back('{"b2b_sh", 1'b1, 3'b001, 32'h20, 32'h0000BEEF, 1, 32'h0});
    exp_q.push_back(mk(2, 1, 0, 0, 1, 32'h000000A5, 32'h20, 32'hBEEFBEEF, 4'b0011));
    st.push_back('{"b2b_lw", 1'b0, 3'b010, 32'h24, 32'h0, 1, 32'h89ABCDEF});
    exp_q.push_back(mk(2, 1, 0, 0, 0, 32'h89ABCDEF, 32'h24, 32'h0, 4'b0000));
    check_list(st);
  endtask

  task automatic test_reset_mid;
    bit saw_done = 0;
    @(posedge clk); #1;
    MemReq = 1; MemWrite = 0; Funct3 = 3'b010; ALUResult = 32'h300;
    @(posedge clk); #1;
    MemReq = 0;
    @(negedge clk);
    total++;
    if (bus_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_req_up: got bus_req=%b want 1", bus_req);
    end
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    total++;
    if ({bus_req, Stall, Done, Fault, BusError, bus_we} !== 6'b0) begin
      bad++;
      $display("FAIL mid_reset_ctrl: got %b want 000000",
               {bus_req, Stall, Done, Fault, BusError, bus_we});
    end
    total++;
    if ({bus_addr, bus_wdata, ReadData, bus_wstrb} !== '0) begin
      bad++;
      $display("FAIL mid_reset_data: got addr=%h wd=%h rd=%h st=%b want zeros",
               bus_addr, bus_wdata, ReadData, bus_wstrb);
    end
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'hFFFF0000;
    @(posedge clk); #1;
    bus_ack = 0; bus_rdata = '0;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (Done || bus_req) saw_done = 1;
    end
    total++;
    if (saw_done) begin
      bad++;
      $display("FAIL mid_no_done: got Done/bus_req after reset want none");
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store();
    test_load_ext();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
